// File: rtl/act_row_feeder.sv
// act_row_feeder: per-row activation feeder for the superblock row.
//   Accepts one upstream word stream tagged with a destination row, buffers
//   each word in that row's FIFO, and hands words to a row only while the
//   row requests, one registered word per cycle.
// Optional feature macro: ACT_FEEDER_BCAST_EN (adds s_bcast broadcast push).
// Ports:
//   clk_h, rst        clock (rising edge), async active-high reset
//   s_data/s_row      upstream word and its destination row
//   s_valid/s_ready   upstream handshake (s_ready combinational on s_row)
//   s_bcast           (ACT_FEEDER_BCAST_EN) push word into every row FIFO
//   flush             synchronous clear of all FIFOs and vld
//   act_data_in       row r word at [r*2*WID_ACT +: 2*WID_ACT]
//   act_data_in_vld   row r received a word this cycle
//   act_data_in_req   row r can take a word this cycle
//   fifo_empty/full   per-row FIFO status
module act_row_feeder #(
  parameter int unsigned N_ROW      = 8,
  parameter int unsigned WID_ACT    = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic                       clk_h,
  input  logic                       rst,
  input  logic [2*WID_ACT-1:0]       s_data,
  input  logic [WID_ROW-1:0]         s_row,
  input  logic                       s_valid,
`ifdef ACT_FEEDER_BCAST_EN
  input  logic                       s_bcast,
`endif
  output logic                       s_ready,
  input  logic                       flush,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]           act_data_in_vld,
  input  logic [N_ROW-1:0]           act_data_in_req,
  output logic [N_ROW-1:0]           fifo_empty,
  output logic [N_ROW-1:0]           fifo_full
);

  localparam int unsigned WID_WORD = 2 * WID_ACT;
  localparam int unsigned WID_FIFO = $clog2(FIFO_DEPTH);
  localparam int unsigned WID_PTR  = WID_FIFO + 1;

  logic [WID_WORD-1:0] mem    [N_ROW][FIFO_DEPTH];
  logic [WID_PTR-1:0]  wr_ptr [N_ROW];
  logic [WID_PTR-1:0]  rd_ptr [N_ROW];
  logic [N_ROW-1:0]    push;
  logic [N_ROW-1:0]    pop;
  logic                row_ok;

  // Tags beyond the last row are accepted and dropped.
  assign row_ok = (32'(s_row) < N_ROW);

  // Status from registered pointers; extra MSB separates full from empty.
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    for (int unsigned r = 0; r < N_ROW; r++) begin
      fifo_empty[r] = (wr_ptr[r] == rd_ptr[r]);
      fifo_full[r]  = (wr_ptr[r][WID_FIFO] != rd_ptr[r][WID_FIFO]) &&
                      (wr_ptr[r][WID_FIFO-1:0] == rd_ptr[r][WID_FIFO-1:0]);
    end
  end

  // Upstream ready; a pop in the same cycle does not free a full FIFO.
  always_comb begin
    s_ready = 1'b0;
    if (!rst && !flush) begin
`ifdef ACT_FEEDER_BCAST_EN
      if (s_bcast) s_ready = ~|fifo_full;
      else
`endif
      if (row_ok) s_ready = !fifo_full[s_row];
      else        s_ready = 1'b1;
    end
  end

  // Per-row push decode.
  always_comb begin
    push = '0;
    if (s_valid && s_ready) begin
`ifdef ACT_FEEDER_BCAST_EN
      if (s_bcast) push = '1;
      else
`endif
      if (row_ok) push[s_row] = 1'b1;
    end
  end

  assign pop = act_data_in_req & ~fifo_empty & {N_ROW{~flush}};

  // Pointers and vld; flush clears pointers but leaves data registers.
  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < N_ROW; r++) begin
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
      end
      act_data_in_vld <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < N_ROW; r++) begin
        wr_ptr[r] <= '0;
        rd_ptr[r] <= '0;
      end
      act_data_in_vld <= '0;
    end else begin
      for (int unsigned r = 0; r < N_ROW; r++) begin
        if (push[r]) wr_ptr[r] <= wr_ptr[r] + WID_PTR'(1);
        if (pop[r])  rd_ptr[r] <= rd_ptr[r] + WID_PTR'(1);
      end
      act_data_in_vld <= pop;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_h) begin
    for (int unsigned r = 0; r < N_ROW; r++) begin
      if (push[r]) mem[r][wr_ptr[r][WID_FIFO-1:0]] <= s_data;
    end
  end

  // Output data registers hold their last word between pops.
  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      act_data_in <= '0;
    end else begin
      for (int unsigned r = 0; r < N_ROW; r++) begin
        if (pop[r]) act_data_in[r*WID_WORD +: WID_WORD] <= mem[r][rd_ptr[r][WID_FIFO-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_act_row_feeder.sv
// tb_act_row_feeder: directed self-checking bench for act_row_feeder.
module tb_act_row_feeder;

  localparam int unsigned N_ROW   = 8;
  localparam int unsigned WID_ACT = 16;
  localparam int unsigned WID_W   = 2 * WID_ACT;

  logic                   clk_h = 1'b0;
  logic                   rst;
  logic [WID_W-1:0]       s_data;
  logic [2:0]             s_row;
  logic                   s_valid;
  logic                   s_bcast;
  logic                   s_ready;
  logic                   flush;
  logic [WID_W*N_ROW-1:0] act_data_in;
  logic [N_ROW-1:0]       act_data_in_vld;
  logic [N_ROW-1:0]       act_data_in_req;
  logic [N_ROW-1:0]       fifo_empty;
  logic [N_ROW-1:0]       fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  act_row_feeder #(.N_ROW(N_ROW), .WID_ACT(WID_ACT), .FIFO_DEPTH(16)) dut (
    .clk_h           (clk_h),
    .rst             (rst),
    .s_data          (s_data),
    .s_row           (s_row),
    .s_valid         (s_valid),
`ifdef ACT_FEEDER_BCAST_EN
    .s_bcast         (s_bcast),
`endif
    .s_ready         (s_ready),
    .flush           (flush),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full)
  );

  always #5 clk_h = ~clk_h;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WID_W-1:0] row_data(input int r);
    return act_data_in[r*WID_W +: WID_W];
  endfunction

  // Drive one unicast word at the negedge; it transfers on the next posedge.
  task automatic push_word(input logic [2:0] row, input logic [WID_W-1:0] d);
    @(negedge clk_h);
    s_valid = 1'b1;
    s_row   = row;
    s_data  = d;
    #1 check("push_rdy", 64'(s_ready), 1);
  endtask

  function automatic logic [WID_W-1:0] exp3(input int k);
    return (k < 16) ? WID_W'(32'h100 + k) : WID_W'(32'h200 + k - 16);
  endfunction

  initial begin
    rst = 1'b1; s_data = '0; s_row = 3'd3; s_valid = 1'b1; s_bcast = 1'b0;
    flush = 1'b0; act_data_in_req = '0;

    // Reset state
    repeat (2) @(negedge clk_h);
    check("rst_empty", 64'(fifo_empty), 8'hFF);
    check("rst_full",  64'(fifo_full), 0);
    check("rst_vld",   64'(act_data_in_vld), 0);
    check("rst_data",  64'(act_data_in), 0);
    check("rst_ready", 64'(s_ready), 0);
    rst = 1'b0; s_valid = 1'b0;

    // 1: single word to row 3, two-edge latency
    act_data_in_req = 8'h08;
    push_word(3'd3, 32'hA5A5_0001);
    @(negedge clk_h);
    s_valid = 1'b0;
    check("t1_vld_early", 64'(act_data_in_vld), 0);
    check("t1_nonempty",  64'(fifo_empty[3]), 0);
    @(negedge clk_h);
    check("t1_vld",  64'(act_data_in_vld), 8'h08);
    check("t1_data", 64'(row_data(3)), 32'hA5A5_0001);
    act_data_in_req = '0;

    // 2: fill row 0 with no request
    for (int i = 0; i < 16; i++) push_word(3'd0, WID_W'(32'h100 + i));
    @(negedge clk_h);
    s_valid = 1'b0;
    check("t2_full0",  64'(fifo_full), 8'h01);
    check("t2_vld",    64'(act_data_in_vld), 0);
    check("t2_hold3",  64'(row_data(3)), 32'hA5A5_0001);
    s_row = 3'd0;
    #1 check("t2_rdy_row0", 64'(s_ready), 0);
    s_row = 3'd1;
    #1 check("t2_rdy_row1", 64'(s_ready), 1);

    // 3: full row 0 drained while continuously refilled
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk_h);
      if (i >= 1 && i <= 39) begin
        check("t3_vld",  64'(act_data_in_vld), 8'h01);
        check("t3_data", 64'(row_data(0)), 64'(exp3(i - 1)));
      end
      if (i == 40) begin
        check("t3_vld_end",   64'(act_data_in_vld), 0);
        check("t3_empty_end", 64'(fifo_empty), 8'hFF);
        act_data_in_req = '0;
      end
      if (i <= 23) begin
        act_data_in_req = 8'h01;
        s_row   = 3'd0;
        s_valid = 1'b1;
        s_data  = (i == 0) ? WID_W'(32'h200) : WID_W'(32'h200 + i - 1);
        #1 check("t3_ready", 64'(s_ready), (i >= 1) ? 1 : 0);
      end else begin
        s_valid = 1'b0;
      end
    end

    // 4: req[2] toggling gives one pulse per req-high cycle
    for (int i = 0; i < 4; i++) push_word(3'd2, WID_W'(32'h300 + i));
    @(negedge clk_h);
    s_valid = 1'b0;
    act_data_in_req = 8'h04;
    @(negedge clk_h);
    check("t4_vld_a",  64'(act_data_in_vld), 8'h04);
    check("t4_data_a", 64'(row_data(2)), 32'h300);
    act_data_in_req = '0;
    @(negedge clk_h);
    check("t4_vld_b", 64'(act_data_in_vld), 0);
    act_data_in_req = 8'h04;
    @(negedge clk_h);
    check("t4_vld_c",  64'(act_data_in_vld), 8'h04);
    check("t4_data_c", 64'(row_data(2)), 32'h301);
    act_data_in_req = '0;
    @(negedge clk_h);
    check("t4_vld_d",  64'(act_data_in_vld), 0);
    check("t4_hold",   64'(row_data(2)), 32'h301);
    check("t4_left",   64'(fifo_empty[2]), 0);

    // 5: flush with rows 1, 2 and 5 non-empty
    push_word(3'd1, 32'h401);
    push_word(3'd1, 32'h402);
    push_word(3'd5, 32'h501);
    push_word(3'd5, 32'h502);
    push_word(3'd5, 32'h503);
    @(negedge clk_h);
    s_valid = 1'b0;
    act_data_in_req = 8'h02;
    @(negedge clk_h);
    check("t5_vld_pre",  64'(act_data_in_vld), 8'h02);
    check("t5_data_pre", 64'(row_data(1)), 32'h401);
    flush = 1'b1; s_valid = 1'b1; s_row = 3'd5; s_data = 32'h5FF;
    #1 check("t5_rdy_flush", 64'(s_ready), 0);
    @(negedge clk_h);
    check("t5_empty", 64'(fifo_empty), 8'hFF);
    check("t5_full",  64'(fifo_full), 0);
    check("t5_vld",   64'(act_data_in_vld), 0);
    check("t5_hold1", 64'(row_data(1)), 32'h401);
    flush = 1'b0; s_data = 32'h555; act_data_in_req = 8'h20;
    #1 check("t5_rdy_after", 64'(s_ready), 1);
    @(negedge clk_h);
    s_valid = 1'b0;
    check("t5_vld_lat", 64'(act_data_in_vld), 0);
    @(negedge clk_h);
    check("t5_vld_new",  64'(act_data_in_vld), 8'h20);
    check("t5_data_new", 64'(row_data(5)), 32'h555);
    @(negedge clk_h);
    check("t5_vld_drop", 64'(act_data_in_vld), 0);

    // Out-of-range tag is not possible with 8 rows; reset mid-burst drops vld at once
    act_data_in_req = 8'h10;
    push_word(3'd4, 32'h777);
    push_word(3'd4, 32'h778);
    @(negedge clk_h);
    s_valid = 1'b0;
    check("t7_vld_pre", 64'(act_data_in_vld), 8'h10);
    rst = 1'b1;
    #1;
    check("t7_vld_rst",   64'(act_data_in_vld), 0);
    check("t7_data_rst",  64'(act_data_in), 0);
    check("t7_empty_rst", 64'(fifo_empty), 8'hFF);
    check("t7_rdy_rst",   64'(s_ready), 0);
    @(negedge clk_h);
    rst = 1'b0;
    act_data_in_req = '0;

`ifdef ACT_FEEDER_BCAST_EN
    // 6: broadcast reaches every row on the same cycle
    @(negedge clk_h);
    act_data_in_req = 8'hFF;
    s_valid = 1'b1; s_bcast = 1'b1; s_row = 3'd0; s_data = 32'h1234_5678;
    #1 check("t6_ready", 64'(s_ready), 1);
    @(negedge clk_h);
    s_valid = 1'b0; s_bcast = 1'b0;
    check("t6_vld_early", 64'(act_data_in_vld), 0);
    @(negedge clk_h);
    check("t6_vld", 64'(act_data_in_vld), 8'hFF);
    for (int r = 0; r < 8; r++) check("t6_data", 64'(row_data(r)), 32'h1234_5678);
    act_data_in_req = '0;
`endif

    @(negedge clk_h);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
